mode_switch_sequencer: RTL

//  Sequences distortion-mode changes for the pedal datapath in the CLOCK_50 domain.

---
 rtl/mode_switch_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mode_switch_sequencer.sv
// mode_switch_sequencer: debounced, pop-free distortion-mode changeover.
// Define MSEQ_SWITCH_COUNT_EN to add the switch_count[7:0] output.
module mode_switch_sequencer #(
    parameter int GW              = 16,
    parameter int RAMP_STEP       = 64,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic [1:0]    sw_raw,
    input  logic          sample_tick,
    output logic [1:0]    mode_out,
    output logic [GW-1:0] gain_out,
    output logic          busy,
    output logic          lcd_req,
    output logic [1:0]    lcd_mode,
    input  logic          lcd_ack
`ifdef MSEQ_SWITCH_COUNT_EN
    ,
    output logic [7:0]    switch_count
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAIN_MAX = '1;
    localparam logic [GW-1:0] STEP     = GW'(RAMP_STEP);
    localparam logic [GW:0]   STEP_W   = (GW+1)'(RAMP_STEP);
    localparam logic [GW:0]   MAX_W    = {1'b0, GAIN_MAX};

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    logic [1:0]    sw_m_q, sw_m_d;
    logic [1:0]    sw_s_q, sw_s_d;
    logic [1:0]    sw_p_q, sw_p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    db_q, db_d;
    state_t        state_q, state_d;
    logic [GW-1:0] gain_q, gain_d;
    logic [1:0]    pending_q, pending_d;
    logic          lcd_req_q, lcd_req_d;
    logic [1:0]    lcd_mode_q, lcd_mode_d;
    logic [GW:0]   gain_up;

    // Wide add so the fade-in saturates instead of wrapping.
    assign gain_up = {1'b0, gain_q} + STEP_W;

    // Synchroniser shift and stability counter; db follows a settled sw_s.
    always_comb begin
        sw_m_d = sw_raw;
        sw_s_d = sw_m_q;
        sw_p_d = sw_s_q;
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sw_s_q != sw_p_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            db_d = sw_s_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Changeover FSM: next state, gain ramp, mode commit, LCD request.
    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        pending_d  = pending_q;
        lcd_req_d  = lcd_req_q;
        lcd_mode_d = lcd_mode_q;
        if (lcd_ack && lcd_req_q) begin
            lcd_req_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                gain_d = GAIN_MAX;
                if (db_q != pending_q) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (sample_tick) begin
                    gain_d = (gain_q > STEP) ? gain_q - STEP : '0;
                end
                if (db_q == pending_q) begin
                    state_d = FADE_IN;
                end else if (gain_q == '0) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                pending_d  = db_q;
                lcd_mode_d = db_q;
                lcd_req_d  = 1'b1;
                state_d    = FADE_IN;
            end
            FADE_IN: begin
                if (sample_tick) begin
                    gain_d = (gain_up > MAX_W) ? GAIN_MAX : gain_up[GW-1:0];
                end
                if (db_q != pending_q) begin
                    state_d = FADE_OUT;
                end else if (gain_q == GAIN_MAX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = SWITCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sw_m_q     <= '0;
            sw_s_q     <= '0;
            sw_p_q     <= '0;
            cnt_q      <= '0;
            db_q       <= '0;
            state_q    <= SWITCH;
            gain_q     <= '0;
            pending_q  <= '0;
            lcd_req_q  <= 1'b0;
            lcd_mode_q <= '0;
        end else begin
            sw_m_q     <= sw_m_d;
            sw_s_q     <= sw_s_d;
            sw_p_q     <= sw_p_d;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            state_q    <= state_d;
            gain_q     <= gain_d;
            pending_q  <= pending_d;
            lcd_req_q  <= lcd_req_d;
            lcd_mode_q <= lcd_mode_d;
        end
    end

    // The committed mode is the pending register; gain is muted during reset.
    assign mode_out = pending_q;
    assign gain_out = reset_n ? gain_q : '0;
    assign busy     = (state_q != IDLE);
    assign lcd_req  = lcd_req_q;
    assign lcd_mode = lcd_mode_q;

`ifdef MSEQ_SWITCH_COUNT_EN
    logic       first_q, first_d;
    logic [7:0] sc_q, sc_d;

    // Count user-initiated commits; the reset-exit commit is skipped.
    always_comb begin
        first_d = first_q;
        sc_d    = sc_q;
        if (state_q == SWITCH) begin
            first_d = 1'b0;
            if (!first_q && sc_q != 8'hFF) begin
                sc_d = sc_q + 8'd1;
            end
        end
    end

    // Switch counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            first_q <= 1'b1;
            sc_q    <= '0;
        end else begin
            first_q <= first_d;
            sc_q    <= sc_d;
        end
    end

    assign switch_count = sc_q;
`endif

endmodule
